ssd_scan_decoder: RTL
=====================

Name: ssd_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder. Monitors a multiplexed, active-low seven-segment display bus (digit enables plus segment lines) and reconstructs the hex nibble shown on each digit.
- Presents a complete multi-digit frame through a valid/ready handshake.
- Used for display loopback checking and for observing external display drivers.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- an  input  DIGITS  digit enables, active-low; a legal select is exactly one bit low.
- seg  input  7  segments, active-low; seg[0]=a … seg[6]=g.
- value  output  4*DIGITS  captured frame; digit k at value[4k+3:4k].
- blank  output  DIGITS  digit k showed all segments off.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts frame.
- err  output  1  sticky: an illegal segment pattern was captured.
- overrun  output  1  sticky: a frame completed while out_valid=1 and out_ready=0.

Behaviour:
- Reset (async): value=0, blank=0, out_valid=0, err=0, overrun=0. Sample registers go to all-ones; stability count=0; seen mask=0. FSM enters IDLE. Reset mid-frame discards partial captures.
- Input stage: an and seg registered once every clk (s_an, s_seg); all decisions use the registered copies.
- Stability count: cnt=1 when {s_an,s_seg} differs from the previous sample; otherwise cnt increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: s_an not one-hot-low. Stay here; cnt keeps running.
  - SETTLE: one-hot select present, cnt<STABLE_CYCLES. A change of s_an or s_seg restarts counting. s_an becoming non-one-hot goes to IDLE.
  - CAPTURE: single cycle in which cnt reaches STABLE_CYCLES. Decode s_seg into the shadow slot of the selected digit, set its seen bit, then go to HOLD.
  - HOLD: no further capture until s_an or s_seg changes, then go to SETTLE or IDLE. Prevents recapturing a static digit.
- Decode (active-low segment pattern → nibble):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110 (written g..a, MSB=g).
  - 1111111 → nibble 0, shadow blank bit set, no error.
  - Any other pattern → nibble 0, blank 0, err set. The slot still counts as seen.
  - Decode is a combinational function inside the FSM.
- Frame completion: the cycle a capture makes seen all-ones, the frame is complete and seen clears in the same cycle.
  - If out_valid=0 or (out_valid & out_ready): copy shadow (including the just-captured slot) to value/blank; out_valid=1 next cycle.
  - Else: frame dropped, overrun=1, value/blank unchanged.
- Handshake: out_valid holds and value/blank stay stable until out_valid & out_ready. If no new frame completes in that cycle, out_valid=0 next cycle. Completion and acceptance in the same cycle load the new frame with no bubble.
- Latency: from the first cycle a digit's pattern is stable at the ports to capture is STABLE_CYCLES+1 cycles. out_valid rises 1 cycle after the completing capture.
- Recapturing the same digit before the frame completes overwrites its shadow slot.
- err and overrun clear only on reset.

Decomposition:
- Package ssd_pkg holds:
  - SEG_BLANK constant (7'b1111111).
  - The 16 segment-pattern constants, shared with the encoder.
  - The FSM state enum {IDLE, SETTLE, CAPTURE, HOLD}.
- One sub-module, ssd_seg_decode: combinational 7-bit → {nibble, blank, illegal}. Directly reusable against the encoder in a loopback bench.

Test Plan:
- Reset, then DIGITS=4, STABLE_CYCLES=4. Scan an=1110,1101,1011,0111 with seg for 1,2,3,4, 8 cycles each → out_valid=1 with value=16'h4321, blank=0, err=0.
- Same scan, but digit 2 holds its pattern for only 3 cycles → no capture; out_valid stays 0 until a later full scan provides digit 2.
- Digit 1 shows seg=1111111, digit 3 shows seg=1010101 → frame completes with blank=0010, value[15:12]=0, err=1 (sticky after next clean frame).
- Keep out_ready=0 and scan two complete frames (0xABCD then 0x1234) → value=16'hABCD held, overrun=1. Raise out_ready → out_valid drops next cycle.
- an=1100 (two low) or 1111 for 20 cycles → no capture, FSM in IDLE. Assert rst mid-scan after 2 digits → seen cleared; a following full scan of 0xF00F yields value=16'hF00F.
- Hold out_ready=1 through continuous scanning of 0x0000…0xFFFF patterns → one out_valid pulse per frame, overrun=0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan decoder and its encoder.
// Segment patterns are active-low and written g..a (bit 6 = g, bit 0 = a).
package ssd_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      HOLD
   } ssd_state_t;

   // Encoder-side helper: nibble to active-low segment pattern.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = SEG_0;
         4'h1: s = SEG_1;
         4'h2: s = SEG_2;
         4'h3: s = SEG_3;
         4'h4: s = SEG_4;
         4'h5: s = SEG_5;
         4'h6: s = SEG_6;
         4'h7: s = SEG_7;
         4'h8: s = SEG_8;
         4'h9: s = SEG_9;
         4'hA: s = SEG_A;
         4'hB: s = SEG_B;
         4'hC: s = SEG_C;
         4'hD: s = SEG_D;
         4'hE: s = SEG_E;
         default: s = SEG_F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational active-low segment pattern to nibble decoder.
// All-off reports blank; any pattern outside the hex set reports illegal.
module ssd_seg_decode
   import ssd_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_nibble,
   output logic       o_blank,
   output logic       o_illegal
);

   // Map the pattern to its nibble, flagging blank and illegal patterns.
   always_comb begin
      o_nibble  = '0;
      o_blank   = 1'b0;
      o_illegal = 1'b0;
      case (i_seg)
         SEG_0:     o_nibble = 4'h0;
         SEG_1:     o_nibble = 4'h1;
         SEG_2:     o_nibble = 4'h2;
         SEG_3:     o_nibble = 4'h3;
         SEG_4:     o_nibble = 4'h4;
         SEG_5:     o_nibble = 4'h5;
         SEG_6:     o_nibble = 4'h6;
         SEG_7:     o_nibble = 4'h7;
         SEG_8:     o_nibble = 4'h8;
         SEG_9:     o_nibble = 4'h9;
         SEG_A:     o_nibble = 4'hA;
         SEG_B:     o_nibble = 4'hB;
         SEG_C:     o_nibble = 4'hC;
         SEG_D:     o_nibble = 4'hD;
         SEG_E:     o_nibble = 4'hE;
         SEG_F:     o_nibble = 4'hF;
         SEG_BLANK: o_blank  = 1'b1;
         default:   o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus, captures each digit
// once its select and pattern have been stable long enough, and presents
// the assembled multi-digit frame through a valid/ready handshake.
module ssd_scan_decoder
   import ssd_pkg::*;
#(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DIGITS-1:0]   an,
   input  logic [6:0]          seg,
   output logic [4*DIGITS-1:0] value,
   output logic [DIGITS-1:0]   blank,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                err,
   output logic                overrun
);

   localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);

   logic [DIGITS-1:0]   r_s_an;
   logic [6:0]          r_s_seg;
   logic [7:0]          r_cnt;
   ssd_state_t          r_state;
   logic [DIGITS-1:0]   r_seen;
   logic [4*DIGITS-1:0] r_sh_val;
   logic [DIGITS-1:0]   r_sh_blk;

   logic                w_chg;
   logic [7:0]          w_cnt_nxt;
   logic [3:0]          w_zeros;
   logic                w_onehot_nxt;
   ssd_state_t          w_state_nxt;
   logic                w_cap;
   logic [3:0]          w_nib;
   logic                w_blk;
   logic                w_ill;
   logic [4*DIGITS-1:0] w_sh_val_nxt;
   logic [DIGITS-1:0]   w_sh_blk_nxt;
   logic [DIGITS-1:0]   w_seen_nxt;
   logic                w_complete;
   logic                w_load;

   ssd_seg_decode u_dec (
      .i_seg     (r_s_seg),
      .o_nibble  (w_nib),
      .o_blank   (w_blk),
      .o_illegal (w_ill)
   );

   // Stability count that will accompany the sample being registered.
   always_comb begin
      w_chg = ({an, seg} != {r_s_an, r_s_seg});
      if (w_chg) begin
         w_cnt_nxt = 8'd1;
      end else if (r_cnt >= C_STABLE) begin
         w_cnt_nxt = C_STABLE;
      end else begin
         w_cnt_nxt = r_cnt + 8'd1;
      end
   end

   // One-hot-low test on the digit select being registered.
   always_comb begin
      w_zeros = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         w_zeros = w_zeros + {3'd0, ~an[k]};
      end
      w_onehot_nxt = (w_zeros == 4'd1);
   end

   // Input sample registers, stability counter and FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s_an  <= '1;
         r_s_seg <= '1;
         r_cnt   <= '0;
         r_state <= IDLE;
      end else begin
         r_s_an  <= an;
         r_s_seg <= seg;
         r_cnt   <= w_cnt_nxt;
         r_state <= w_state_nxt;
      end
   end

   // Next state is derived from the sample being registered so that the
   // CAPTURE cycle sees the stable pattern in r_s_an/r_s_seg.
   always_comb begin
      w_state_nxt = r_state;
      w_cap       = (r_state == CAPTURE);
      if (!w_onehot_nxt) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE, SETTLE:  w_state_nxt = (w_cnt_nxt == C_STABLE) ? CAPTURE : SETTLE;
            CAPTURE, HOLD: w_state_nxt = w_chg ? SETTLE : HOLD;
            default:       w_state_nxt = IDLE;
         endcase
      end
   end

   // Merge the captured digit into the shadow frame and detect completion.
   always_comb begin
      w_sh_val_nxt = r_sh_val;
      w_sh_blk_nxt = r_sh_blk;
      w_seen_nxt   = r_seen;
      if (w_cap) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            if (!r_s_an[k]) begin
               w_sh_val_nxt[4*k +: 4] = w_nib;
               w_sh_blk_nxt[k]        = w_blk;
               w_seen_nxt[k]          = 1'b1;
            end
         end
      end
      w_complete = w_cap && (&w_seen_nxt);
      w_load     = w_complete && (!out_valid || out_ready);
   end

   // Shadow frame storage and seen mask.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_val <= '0;
         r_sh_blk <= '0;
         r_seen   <= '0;
      end else begin
         r_sh_val <= w_sh_val_nxt;
         r_sh_blk <= w_sh_blk_nxt;
         r_seen   <= w_complete ? '0 : w_seen_nxt;
      end
   end

   // Output frame, handshake and sticky status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value     <= '0;
         blank     <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (w_load) begin
            value     <= w_sh_val_nxt;
            blank     <= w_sh_blk_nxt;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (w_complete && !w_load) begin
            overrun <= 1'b1;
         end
         if (w_cap && w_ill) begin
            err <= 1'b1;
         end
      end
   end

endmodule
